// File: rtl/lsu_load_tracker.sv
// lsu_load_tracker: in-order queue of outstanding data-memory loads. Matches each
// memory response to the ROB id of the oldest load, formats the returned word
// by size/sign/offset, and emits a one-cycle finish pulse. A ROB flush marks
// every tracked load as killed so its response is drained without reporting.
module lsu_load_tracker #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            iss_valid,
    input  logic [ID_W-1:0] iss_id,
    input  logic [1:0]      iss_size,
    input  logic            iss_signed,
    input  logic [1:0]      iss_off,
    output logic            iss_ready,
    input  logic            mem_resp_valid,
    input  logic [31:0]     mem_rdata,
    output logic            rfin,
    output logic [ID_W-1:0] rid,
    output logic [31:0]     rdata,
    output logic            busy,
    output logic            resp_err
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ID_W-1:0] ent_id     [DEPTH];
    logic [1:0]      ent_size   [DEPTH];
    logic            ent_signed [DEPTH];
    logic [1:0]      ent_off    [DEPTH];
    logic            ent_killed [DEPTH];

    // Pointers carry an extra wrap bit so full and empty can be told apart.
    logic [PTR_W:0]   head;
    logic [PTR_W:0]   tail;
    logic [PTR_W-1:0] head_idx;
    logic [PTR_W-1:0] tail_idx;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             live_pop;
    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;
    logic [31:0]      fmt_data;

    assign head_idx  = head[PTR_W-1:0];
    assign tail_idx  = tail[PTR_W-1:0];
    assign full      = (head_idx == tail_idx) && (head[PTR_W] != tail[PTR_W]);
    assign empty     = (head == tail);
    assign iss_ready = ~full;
    assign busy      = ~empty;
    assign push      = iss_valid & ~full & ~flush;
    assign pop       = mem_resp_valid & ~empty;
    assign live_pop  = pop & ~ent_killed[head_idx] & ~flush;

    // Extract and extend the loaded value using the head entry's size, sign and offset.
    always_comb begin
        sel_byte = mem_rdata[7:0];
        case (ent_off[head_idx])
            2'd0:    sel_byte = mem_rdata[7:0];
            2'd1:    sel_byte = mem_rdata[15:8];
            2'd2:    sel_byte = mem_rdata[23:16];
            default: sel_byte = mem_rdata[31:24];
        endcase
        sel_half = ent_off[head_idx][1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ent_size[head_idx])
            2'd0:    fmt_data = {{24{ent_signed[head_idx] & sel_byte[7]}}, sel_byte};
            2'd1:    fmt_data = {{16{ent_signed[head_idx] & sel_half[15]}}, sel_half};
            default: fmt_data = mem_rdata;
        endcase
    end

    // Advance head on any pop and tail on an accepted push; reset empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (pop)  head <= head + 1'b1;
            if (push) tail <= tail + 1'b1;
        end
    end

    // Entry payload is written on push; a flush kills everything currently held.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_id[tail_idx]     <= iss_id;
            ent_size[tail_idx]   <= iss_size;
            ent_signed[tail_idx] <= iss_signed;
            ent_off[tail_idx]    <= iss_off;
            ent_killed[tail_idx] <= 1'b0;
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_killed[i] <= 1'b1;
            end
        end
    end

    // Register the finish pulse; id and data only change on a live pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rfin  <= 1'b0;
            rid   <= '0;
            rdata <= '0;
        end else begin
            rfin <= live_pop;
            if (live_pop) begin
                rid   <= ent_id[head_idx];
                rdata <= fmt_data;
            end
        end
    end

    // A response with nothing outstanding is a sticky error until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_err <= 1'b0;
        end else if (mem_resp_valid && empty) begin
            resp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lsu_load_tracker.sv
// tb_lsu_load_tracker: directed vectors with hand-computed expectations for
// lsu_load_tracker (DEPTH=4, ID_W=7).
module tb_lsu_load_tracker;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        iss_valid;
    logic [6:0]  iss_id;
    logic [1:0]  iss_size;
    logic        iss_signed;
    logic [1:0]  iss_off;
    logic        iss_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        rfin;
    logic [6:0]  rid;
    logic [31:0] rdata;
    logic        busy;
    logic        resp_err;

    int assert_count = 0;
    int fail_count   = 0;
    logic [6:0] exp_ids[$];
    logic [6:0] exp_id;

    lsu_load_tracker #(.DEPTH(4), .ID_W(7)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .iss_valid(iss_valid),
        .iss_id(iss_id),
        .iss_size(iss_size),
        .iss_signed(iss_signed),
        .iss_off(iss_off),
        .iss_ready(iss_ready),
        .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata),
        .rfin(rfin),
        .rid(rid),
        .rdata(rdata),
        .busy(busy),
        .resp_err(resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and tally the result.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then advance to just after the next rising edge.
    task automatic applyStimulus(input logic iv, input logic [6:0] id, input logic [1:0] sz,
                                 input logic sg, input logic [1:0] off, input logic rv,
                                 input logic [31:0] rd, input logic fl);
        iss_valid      = iv;
        iss_id         = id;
        iss_size       = sz;
        iss_signed     = sg;
        iss_off        = off;
        mem_resp_valid = rv;
        mem_rdata      = rd;
        flush          = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 7'd0, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        iss_valid = 1'b0; iss_id = '0; iss_size = '0; iss_signed = 1'b0; iss_off = '0;
        mem_resp_valid = 1'b0; mem_rdata = '0; flush = 1'b0;
        idle();
        idle();
        checkOutput("rst_rfin", {31'd0, rfin}, 32'd0);
        checkOutput("rst_rid", {25'd0, rid}, 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        checkOutput("rst_resp_err", {31'd0, resp_err}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_ready", {31'd0, iss_ready}, 32'd1);
        rst = 1'b0;

        // Test 1: signed byte at offset 2
        applyStimulus(1'b1, 7'd5, 2'd0, 1'b1, 2'd2, 1'b0, 32'h0, 1'b0);
        checkOutput("t1_busy", {31'd0, busy}, 32'd1);
        checkOutput("t1_rfin_early", {31'd0, rfin}, 32'd0);
        applyStimulus(1'b0, 7'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'h12803456, 1'b0);
        checkOutput("t1_rfin", {31'd0, rfin}, 32'd1);
        checkOutput("t1_rid", {25'd0, rid}, 32'd5);
        checkOutput("t1_rdata", rdata, 32'hFFFFFF80);
        idle();
        checkOutput("t1_rfin_drop", {31'd0, rfin}, 32'd0);
        checkOutput("t1_rid_hold", {25'd0, rid}, 32'd5);
        checkOutput("t1_busy_drop", {31'd0, busy}, 32'd0);

        // Test 2: fill the queue, issue while full, drain back-to-back
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("t2_ready_before_%0d", i), {31'd0, iss_ready}, 32'd1);
            applyStimulus(1'b1, 7'(i), 2'd2, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
        end
        checkOutput("t2_ready_full", {31'd0, iss_ready}, 32'd0);
        applyStimulus(1'b1, 7'd9, 2'd2, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
        checkOutput("t2_ready_still_full", {31'd0, iss_ready}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus((i == 1), 7'd20, 2'd2, 1'b0, 2'd0, 1'b1, 32'hC0DE0000 + 32'(i), 1'b0);
            checkOutput($sformatf("t2_rfin_%0d", i), {31'd0, rfin}, 32'd1);
            checkOutput($sformatf("t2_rid_%0d", i), {25'd0, rid}, 32'(i));
            checkOutput($sformatf("t2_rdata_%0d", i), rdata, 32'hC0DE0000 + 32'(i));
            if (i == 1) checkOutput("t2_ready_after_pop", {31'd0, iss_ready}, 32'd1);
        end
        idle();
        checkOutput("t2_rfin_end", {31'd0, rfin}, 32'd0);
        checkOutput("t2_busy_end", {31'd0, busy}, 32'd0);

        // Test 3: half and word formatting
        applyStimulus(1'b1, 7'd6, 2'd1, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 7'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'hBEEF0000, 1'b0);
        checkOutput("t3_half_u", rdata, 32'h0000BEEF);
        applyStimulus(1'b1, 7'd7, 2'd1, 1'b1, 2'd2, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 7'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'hBEEF0000, 1'b0);
        checkOutput("t3_half_s", rdata, 32'hFFFFBEEF);
        applyStimulus(1'b1, 7'd8, 2'd2, 1'b1, 2'd1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 7'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'hDEADBEEF, 1'b0);
        checkOutput("t3_word", rdata, 32'hDEADBEEF);
        checkOutput("t3_word_rid", {25'd0, rid}, 32'd8);
        applyStimulus(1'b1, 7'd9, 2'd1, 1'b1, 2'd1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 7'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'h12348001, 1'b0);
        checkOutput("t3_half_off1", rdata, 32'hFFFF8001);
        applyStimulus(1'b1, 7'd3, 2'd0, 1'b0, 2'd3, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 7'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'hA5000000, 1'b0);
        checkOutput("t3_byte_u_off3", rdata, 32'h000000A5);
        idle();

        // Test 4: flush squashes outstanding loads and drops the concurrent issue
        applyStimulus(1'b1, 7'd10, 2'd2, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 7'd11, 2'd2, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 7'd12, 2'd2, 1'b0, 2'd0, 1'b0, 32'h0, 1'b1);
        checkOutput("t4_busy_flush", {31'd0, busy}, 32'd1);
        applyStimulus(1'b0, 7'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'h11111111, 1'b0);
        checkOutput("t4_rfin_k1", {31'd0, rfin}, 32'd0);
        checkOutput("t4_busy_k1", {31'd0, busy}, 32'd1);
        applyStimulus(1'b0, 7'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'h22222222, 1'b0);
        checkOutput("t4_rfin_k2", {31'd0, rfin}, 32'd0);
        checkOutput("t4_busy_k2", {31'd0, busy}, 32'd0);
        checkOutput("t4_err_clear", {31'd0, resp_err}, 32'd0);
        applyStimulus(1'b0, 7'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'h33333333, 1'b0);
        checkOutput("t4_err_set", {31'd0, resp_err}, 32'd1);
        checkOutput("t4_rfin_empty", {31'd0, rfin}, 32'd0);
        checkOutput("t4_rid_hold", {25'd0, rid}, 32'd3);
        // A response in the flush cycle pops the head silently
        applyStimulus(1'b1, 7'd13, 2'd2, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 7'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'h44444444, 1'b1);
        checkOutput("t4_rfin_flushpop", {31'd0, rfin}, 32'd0);
        checkOutput("t4_busy_flushpop", {31'd0, busy}, 32'd0);
        idle();
        checkOutput("t4_err_sticky", {31'd0, resp_err}, 32'd1);

        // Test 5: simultaneous push/pop with pointer wrap
        for (int i = 40; i <= 42; i++) begin
            applyStimulus(1'b1, 7'(i), 2'd2, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
            exp_ids.push_back(7'(i));
        end
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 7'(43 + k), 2'd2, 1'b0, 2'd0, 1'b1, 32'h50000000 + 32'(k), 1'b0);
            exp_ids.push_back(7'(43 + k));
            exp_id = exp_ids.pop_front();
            checkOutput($sformatf("t5_rfin_%0d", k), {31'd0, rfin}, 32'd1);
            checkOutput($sformatf("t5_rid_%0d", k), {25'd0, rid}, {25'd0, exp_id});
            checkOutput($sformatf("t5_ready_%0d", k), {31'd0, iss_ready}, 32'd1);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 7'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'h60000000, 1'b0);
            exp_id = exp_ids.pop_front();
            checkOutput($sformatf("t5_drain_rid_%0d", k), {25'd0, rid}, {25'd0, exp_id});
            checkOutput($sformatf("t5_drain_busy_%0d", k), {31'd0, busy}, (k == 2) ? 32'd0 : 32'd1);
        end
        idle();

        // Test 6: reset with loads outstanding and a response pending
        applyStimulus(1'b1, 7'd60, 2'd2, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 7'd61, 2'd2, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, 7'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'h77777777, 1'b0);
        checkOutput("t6_rfin", {31'd0, rfin}, 32'd0);
        checkOutput("t6_busy", {31'd0, busy}, 32'd0);
        checkOutput("t6_ready", {31'd0, iss_ready}, 32'd1);
        checkOutput("t6_err", {31'd0, resp_err}, 32'd0);
        checkOutput("t6_rid", {25'd0, rid}, 32'd0);
        rst = 1'b0;
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
